uart_tx: RTL
============

# uart_tx

Memory-mapped UART transmitter that drives the SoC `tx` pin. It accepts bytes from the processor's store path through a single-cycle write strobe and buffers them in a small FIFO. Each byte is serialised as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) at a fixed clocks-per-bit rate. It is the stage directly downstream of the processor/data-memory bus and upstream of the `tx` pin observed by the system bench.

## Interface
- `CLKS_PER_BIT`, default 16, clock cycles per serial bit; legal range ≥1.
- `FIFO_DEPTH`, default 4, byte entries; power of two, ≥2.

Ports:
- `clk` input 1 — single clock; all logic on posedge.
- `reset` input 1 — synchronous, active-high.
- `wr_en` input 1 — write strobe from bus decode; one byte per asserted cycle.
- `wr_data` input 8 — byte to transmit; sampled when `wr_en`=1.
- `full` output 1 — FIFO holds `FIFO_DEPTH` entries.
- `busy` output 1 — FSM not IDLE, or FIFO non-empty.
- `tx` output 1 — serial line; idle high.

## Operation
- Reset values: `tx`=1, `full`=0, `busy`=0, FIFO empty, FSM=IDLE, baud counter=0, bit index=0.
- Write acceptance:
  - `wr_en`=1 while `full`=0 pushes `wr_data`.
  - `wr_en`=1 while `full`=1 drops the byte silently; no state change.
  - `full` is evaluated before any same-cycle pop, so a write on a full cycle is dropped even if a pop occurs.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into shift register, `tx`←0, go to START.
  - START: after `CLKS_PER_BIT` cycles, `tx`←bit0, go to DATA.
  - DATA: each `CLKS_PER_BIT` cycles, shift to the next bit. After bit7 has been held its full period, `tx`←1 and go to STOP.
  - STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. Then:
    - FIFO non-empty: pop, `tx`←0, go to START (no idle gap between frames).
    - FIFO empty: go to IDLE.
- Baud counter runs 0..`CLKS_PER_BIT`-1 and wraps. Width is `$clog2(CLKS_PER_BIT)`, minimum 1 bit. Bit index is 3 bits.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Push to an empty FIFO while in IDLE: the byte is popped on the next cycle, not the same cycle.
- `reset` mid-frame: the frame is aborted, `tx` returns to 1 on the next edge, and FIFO contents are discarded.

## Timing
- `tx` is a registered output; `full` and `busy` are combinational from registered state.
- Latency: `wr_en` sampled at edge k (idle, empty FIFO) → `tx` falls after edge k+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from `tx` falling to either the next start bit or IDLE.
- Back-to-back frames: the stop bit of frame n is followed immediately by the start bit of frame n+1.
- `full` asserts the cycle after the push that fills the FIFO. It deasserts the cycle after the pop.
- `busy` falls the cycle after the last stop bit completes with the FIFO empty.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - `UART_DATA_BITS`=8.
  - `UART_FRAME_BITS`=10.
- Sub-module `sync_fifo`:
  - Parameterised width and depth, single clock, synchronous reset.
  - Ports: push, pop, din, dout, full, empty.
  - `dout` shows the head combinationally.
  - Reusable later by a `uart_rx` block.
- `uart_tx` holds the FSM, baud counter, bit index and shift register.

## Test plan
- Reset: hold `reset` 5 cycles → `tx`=1, `busy`=0, `full`=0 throughout; `wr_en` during reset is ignored.
- Single byte, `CLKS_PER_BIT`=4: write 0xA5 → `tx` waveform 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit 4 cycles, 40 cycles total; `busy` drops the next cycle.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles → two frames with no gap between the stop bit and the second start bit; 80 cycles total.
- Overflow, depth 4, `CLKS_PER_BIT`=4:
  - Write 6 bytes 0x01–0x06 on consecutive cycles.
  - The first is popped the next cycle, so 0x01–0x05 are accepted and 0x06 is dropped.
  - `full` is high after the 5th write.
  - Exactly 5 frames appear.
- Reset mid-frame: write 0xFF and 0x00, assert `reset` during bit3 of the first frame → `tx`=1 on the next edge, FIFO empty, no further frames.
- `CLKS_PER_BIT`=1: write 0x80 → 10-cycle frame 0,0,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: frame geometry and the transmit FSM states.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output. Push is ignored when full
// and pop is ignored when empty, so callers may strobe them freely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Occupancy flags come straight from the registered count.
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Next pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; entries are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes written on the bus are queued in a FIFO and
// serialised LSB first at CLKS_PER_BIT clocks per bit. Frames run back to back
// while the FIFO has data.
//
// Handshake: there is no ready signal. A byte is taken on every clock where
// wr_en=1 and full=0; with full=1 the byte is dropped. full reflects the
// registered occupancy, so a same-cycle pop never makes room for that write.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       tx
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [7:0]        fifo_dout;
    logic              baud_done;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_done = (baud_q == BAUD_LAST);
    assign full      = fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign tx        = tx_q;

    // Next-state logic: the shift register is consumed from bit 0 so tx always
    // takes shift_q[0] when moving to the next data bit.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in progress and returns tx high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule
